// File: rtl/rpc_flow_rx_queues.sv
// Per-flow RPC request queues in one shared RAM with round-robin dispatch to a single output register.
// Optional drop statistics (overflow, drop_cnt) are built only when RPC_FLOW_QUEUE_DROP_STATS_EN is defined.
module rpc_flow_rx_queues #(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LQUEUE_DEPTH      = 3,
  parameter int DATA_WIDTH        = 512
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]    in_flow_id,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [LMAX_NUM_OF_FLOWS-1:0]    out_flow_id,
  input  logic                            out_ready,
  output logic [2**LMAX_NUM_OF_FLOWS-1:0] flow_not_empty,
  output logic                            overflow,
  output logic [31:0]                     drop_cnt
);

  localparam int NUM_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int DEPTH     = 2**LQUEUE_DEPTH;

  typedef logic [LMAX_NUM_OF_FLOWS-1:0] flow_t;
  typedef logic [LQUEUE_DEPTH-1:0]      ptr_t;
  typedef logic [LQUEUE_DEPTH:0]        cnt_t;

  logic [DATA_WIDTH-1:0] mem [NUM_FLOWS*DEPTH];
  ptr_t  wr_ptr    [NUM_FLOWS];
  ptr_t  rd_ptr    [NUM_FLOWS];
  cnt_t  count     [NUM_FLOWS];
  cnt_t  count_nxt [NUM_FLOWS];
  flow_t rr_ptr;

  logic                 push;
  logic                 push_ok;
  logic                 found;
  logic                 load;
  flow_t                grant;
  flow_t                cand;
  logic [NUM_FLOWS-1:0] non_empty;
  logic [NUM_FLOWS-1:0] inc;
  logic [NUM_FLOWS-1:0] dec;

  always_comb begin
    push    = enable && in_valid;
    // Full check uses the start-of-cycle count, so a same-cycle pop never rescues a push.
    push_ok = push && (count[in_flow_id] != cnt_t'(DEPTH));
    for (int f = 0; f < NUM_FLOWS; f++) begin
      non_empty[f] = (count[f] != '0);
    end
    grant = rr_ptr;
    cand  = rr_ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_FLOWS; k++) begin
      cand = flow_t'(rr_ptr + flow_t'(k));
      if (!found && non_empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    load = enable && (!out_valid || out_ready) && found;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      inc[f]       = push_ok && (in_flow_id == flow_t'(f));
      dec[f]       = load && (grant == flow_t'(f));
      count_nxt[f] = count[f] + cnt_t'(inc[f]) - cnt_t'(dec[f]);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[{in_flow_id, wr_ptr[in_flow_id]}] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        wr_ptr[f] <= '0;
        rd_ptr[f] <= '0;
        count[f]  <= '0;
      end
      flow_not_empty <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_flow_id    <= '0;
      rr_ptr         <= flow_t'(NUM_FLOWS - 1);
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        if (inc[f]) wr_ptr[f] <= wr_ptr[f] + ptr_t'(1);
        if (dec[f]) rd_ptr[f] <= rd_ptr[f] + ptr_t'(1);
        count[f]          <= count_nxt[f];
        flow_not_empty[f] <= (count_nxt[f] != '0);
      end
      if (load) begin
        out_valid   <= 1'b1;
        out_data    <= mem[{grant, rd_ptr[grant]}];
        out_flow_id <= grant;
        rr_ptr      <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RPC_FLOW_QUEUE_DROP_STATS_EN
  logic drop;
  assign drop = push && !push_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`else
  assign overflow = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rpc_flow_rx_queues.sv
// Directed and random test of rpc_flow_rx_queues against a queue-based behavioural model.
// Drop-statistics expectations follow whether RPC_FLOW_QUEUE_DROP_STATS_EN is defined.
module tb_rpc_flow_rx_queues;
  localparam int LF = 2;
  localparam int LQ = 3;
  localparam int DW = 64;
  localparam int NF = 2**LF;
  localparam int D  = 2**LQ;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [LF-1:0] in_flow_id = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LF-1:0] out_flow_id;
  logic          out_ready = 1'b1;
  logic [NF-1:0] flow_not_empty;
  logic          overflow;
  logic [31:0]   drop_cnt;

  rpc_flow_rx_queues #(.LMAX_NUM_OF_FLOWS(LF), .LQUEUE_DEPTH(LQ), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_flow_id(in_flow_id), .out_valid(out_valid), .out_data(out_data),
    .out_flow_id(out_flow_id), .out_ready(out_ready), .flow_not_empty(flow_not_empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per flow plus the single output slot.
  logic [DW-1:0] m_q [NF][$];
  logic          m_ov;
  logic [DW-1:0] m_od;
  int            m_of;
  int            m_rr;
  logic          m_ovf;
  logic [31:0]   m_drop;

  int hs_cnt;
  int hs_flow[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_drop();
`ifdef RPC_FLOW_QUEUE_DROP_STATS_EN
    return m_drop;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic exp_ovf();
`ifdef RPC_FLOW_QUEUE_DROP_STATS_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    int  gf;
    bit  push_ok;
    int  fi;
    gf = -1;
    push_ok = 0;
    fi = int'(in_flow_id);
    if (reset) begin
      for (int f = 0; f < NF; f++) m_q[f].delete();
      m_ov = 0; m_od = '0; m_of = 0; m_rr = NF - 1; m_ovf = 0; m_drop = '0;
      return;
    end
    if (enable && in_valid) begin
      if (m_q[fi].size() < D) push_ok = 1;
      else begin
        m_ovf = 1;
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end
    end
    if (enable && (!m_ov || out_ready)) begin
      for (int k = 1; k <= NF; k++) begin
        if (gf < 0 && m_q[(m_rr + k) % NF].size() != 0) gf = (m_rr + k) % NF;
      end
    end
    if (gf >= 0) begin
      m_od = m_q[gf].pop_front();
      m_of = gf;
      m_ov = 1;
      m_rr = gf;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    if (push_ok) m_q[fi].push_back(in_data);
  endtask

  task automatic check_all();
    logic [NF-1:0] fne;
    for (int f = 0; f < NF; f++) fne[f] = (m_q[f].size() != 0);
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", out_data, m_od);
    chk("out_flow_id", 64'(out_flow_id), 64'(m_of));
    chk("flow_not_empty", 64'(flow_not_empty), 64'(fne));
    chk("overflow", 64'(overflow), 64'(exp_ovf()));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop()));
  endtask

  task automatic cycle();
    if (out_valid && out_ready) begin
      hs_cnt++;
      hs_flow.push_back(int'(out_flow_id));
    end
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(int f);
    in_valid   = 1'b1;
    in_flow_id = LF'(f);
    in_data    = {$urandom, $urandom};
    cycle();
    in_valid   = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic hs_clear();
    hs_cnt = 0;
    hs_flow.delete();
  endtask

  initial begin
    int rr_exp[6];
    int n1;
    rr_exp = '{0, 1, 3, 0, 1, 3};
    hs_clear();
    #1;
    idle(2);
    reset = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_fne", 64'(flow_not_empty), 64'd0);
    idle(7);

    // single request
    in_valid = 1'b1; in_flow_id = 2'd2; in_data = 64'hA5;
    cycle();
    in_valid = 1'b0;
    chk("single_fne_n1", 64'(flow_not_empty), 64'b0100);
    chk("single_valid_n1", 64'(out_valid), 64'd0);
    cycle();
    chk("single_valid_n2", 64'(out_valid), 64'd1);
    chk("single_data", out_data, 64'hA5);
    chk("single_flow", 64'(out_flow_id), 64'd2);
    chk("single_fne_n2", 64'(flow_not_empty), 64'd0);
    idle(2);

    // round robin
    out_ready = 1'b0;
    push(0); push(0); push(1); push(1); push(3); push(3);
    idle(1);
    out_ready = 1'b1;
    hs_clear();
    idle(6);
    chk("rr_back_to_back", 64'(hs_cnt), 64'd6);
    for (int i = 0; i < 6; i++) chk("rr_order", 64'(hs_flow[i]), 64'(rr_exp[i]));
    idle(3);

    // wrap with simultaneous push/pop
    hs_clear();
    for (int i = 0; i < 20; i++) push(0);
    idle(4);
    chk("wrap_count", 64'(hs_cnt), 64'd20);
    chk("wrap_drops", 64'(drop_cnt), 64'd0);

    // overflow while the output slot is held
    out_ready = 1'b0;
    push(0);
    idle(1);
    for (int i = 0; i < 10; i++) push(1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'(exp_drop()));
`ifdef RPC_FLOW_QUEUE_DROP_STATS_EN
    chk("ovf_drop_two", 64'(drop_cnt), 64'd2);
    chk("ovf_sticky", 64'(overflow), 64'd1);
`endif
    out_ready = 1'b1;
    hs_clear();
    idle(12);
    n1 = 0;
    foreach (hs_flow[i]) if (hs_flow[i] == 1) n1++;
    chk("ovf_drain_count", 64'(n1), 64'd8);
    chk("ovf_drain_done", 64'(out_valid), 64'd0);

    // back-pressure then reset
    out_ready = 1'b0;
    push(2);
    push(3);
    idle(5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_fne", 64'(flow_not_empty), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    out_ready = 1'b1;
    push(0);
    cycle();
    chk("rst_first_grant", 64'(out_flow_id), 64'd0);
    idle(2);

    // enable gating
    enable = 1'b0;
    push(2); push(2); push(2);
    chk("en_nothing_stored", 64'(flow_not_empty), 64'd0);
    enable = 1'b1;
    hs_clear();
    push(2);
    idle(4);
    chk("en_one_output", 64'(hs_cnt), 64'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_valid   = ($urandom_range(0, 9) < 7);
      in_flow_id = LF'($urandom_range(0, 2));
      in_data    = {$urandom, $urandom};
      cycle();
    end
    reset = 1'b0; in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
    idle(40);
    chk("final_empty", 64'(flow_not_empty), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
